jt1942_rom_arb: RTL

Arbitrates four game-side ROM requesters (main CPU, sound CPU, char/scroll, object) onto the single sdram_req/sdram_ack/data_rdy/data_read port exported by jtframe_mist. Each slot keeps a one-word cache of its last fetched address, so repeated reads complete without an SDRAM access. The block sits inside jt1942_game between the video/CPU fetch logic and the frame SDRAM port. It also drives refresh_en so refresh only runs when no fetch is pending.

---
 rtl/jt1942_rom_arb.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/jt1942_rom_arb.sv
// jt1942_rom_arb
//
// Arbitrates four ROM requesters (main CPU, sound CPU, char/scroll, object)
// onto the single frame SDRAM read port. Each slot keeps a one-word cache of
// the last word fetched for it, so repeated reads of the same address are
// served locally without an SDRAM access. Slot 0 has the highest priority.
//
// Ports:
//   clk_i          system clock, all logic on the rising edge
//   rst_i          synchronous active-high reset (clears everything)
//   loop_rst_i     SDRAM init in progress: abort fetch, invalidate caches
//   downloading_i  ROM download active: same effect as loop_rst_i
//   slot_req_i     per-slot level request, bit 0 = highest priority
//   slot_addr_i    per-slot word address, slot i at [i*AW +: AW]
//   slot_dout_o    per-slot cached data word, registered
//   slot_ok_o      slot i data valid for the current slot address
//   sdram_req_o    registered request to the SDRAM controller
//   sdram_addr_o   registered address accompanying sdram_req_o
//   sdram_ack_i    controller accepted the request (1-cycle pulse)
//   data_rdy_i     data_read_i valid (1-cycle pulse)
//   data_read_i    SDRAM read word
//   refresh_en_o   high when SDRAM refresh is allowed (nothing pending)
module jt1942_rom_arb #(
    parameter int unsigned AW = 22,
    parameter int unsigned DW = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            loop_rst_i,
    input  logic            downloading_i,
    input  logic [3:0]      slot_req_i,
    input  logic [4*AW-1:0] slot_addr_i,
    output logic [4*DW-1:0] slot_dout_o,
    output logic [3:0]      slot_ok_o,
    output logic            sdram_req_o,
    output logic [AW-1:0]   sdram_addr_o,
    input  logic            sdram_ack_i,
    input  logic            data_rdy_i,
    input  logic [DW-1:0]   data_read_i,
    output logic            refresh_en_o
);

    typedef enum logic [1:0] {
        StIdle,
        StWaitAck,
        StWaitRdy
    } state_e;

    state_e state_q, state_d;

    logic [3:0]    valid_q, valid_d;
    logic [AW-1:0] tag_q  [4];
    logic [AW-1:0] tag_d  [4];
    logic [DW-1:0] dout_q [4];
    logic [DW-1:0] dout_d [4];
    logic [1:0]    sel_q, sel_d;
    logic          sdram_req_q, sdram_req_d;
    logic [AW-1:0] sdram_addr_q, sdram_addr_d;

    logic [3:0] hit;
    logic [3:0] need;
    logic       any_need;
    logic [1:0] pick;
    logic       abort;
    logic       fill;

    // Cache lookup against the registered tags; a slot only needs the SDRAM
    // when it is requesting and its cached word does not match.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            hit[i]  = valid_q[i] & slot_req_i[i] & (slot_addr_i[i*AW +: AW] == tag_q[i]);
            need[i] = slot_req_i[i] & ~hit[i];
        end
    end

    assign any_need = |need;

    // Fixed priority: lowest index wins.
    always_comb begin
        pick = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (need[i]) begin
                pick = 2'(i);
            end
        end
    end

    assign abort = loop_rst_i | downloading_i;

    // Data may arrive together with the ack; either way the word completes
    // the outstanding fetch. A data_rdy before the ack belongs to nobody.
    assign fill = ~abort & data_rdy_i &
                  ((state_q == StWaitRdy) | ((state_q == StWaitAck) & sdram_ack_i));

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (any_need) begin
                        state_d = StWaitAck;
                    end
                end
                StWaitAck: begin
                    if (sdram_ack_i) begin
                        state_d = data_rdy_i ? StIdle : StWaitRdy;
                    end
                end
                StWaitRdy: begin
                    if (data_rdy_i) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Output / datapath next-state logic
    always_comb begin
        valid_d      = valid_q;
        sel_d        = sel_q;
        sdram_req_d  = sdram_req_q;
        sdram_addr_d = sdram_addr_q;
        for (int i = 0; i < 4; i++) begin
            tag_d[i]  = tag_q[i];
            dout_d[i] = dout_q[i];
        end

        if (abort) begin
            // Cached words and tags survive; only validity is dropped.
            valid_d     = '0;
            sdram_req_d = 1'b0;
        end else begin
            if ((state_q == StIdle) && any_need) begin
                sel_d          = pick;
                sdram_addr_d   = slot_addr_i[pick*AW +: AW];
                sdram_req_d    = 1'b1;
                // The old word is being replaced; stop serving it.
                valid_d[pick]  = 1'b0;
            end
            if ((state_q == StWaitAck) && sdram_ack_i) begin
                sdram_req_d = 1'b0;
            end
            if (fill) begin
                // Stored under the latched address, even if the slot has
                // since moved on; it then simply reads as a miss.
                valid_d[sel_q] = 1'b1;
                tag_d[sel_q]   = sdram_addr_q;
                dout_d[sel_q]  = data_read_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q      <= '0;
            sel_q        <= '0;
            sdram_req_q  <= 1'b0;
            sdram_addr_q <= '0;
            for (int i = 0; i < 4; i++) begin
                tag_q[i]  <= '0;
                dout_q[i] <= '0;
            end
        end else begin
            valid_q      <= valid_d;
            sel_q        <= sel_d;
            sdram_req_q  <= sdram_req_d;
            sdram_addr_q <= sdram_addr_d;
            for (int i = 0; i < 4; i++) begin
                tag_q[i]  <= tag_d[i];
                dout_q[i] <= dout_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            slot_dout_o[i*DW +: DW] = dout_q[i];
        end
    end

    assign slot_ok_o    = hit;
    assign sdram_req_o  = sdram_req_q;
    assign sdram_addr_o = sdram_addr_q;
    assign refresh_en_o = (state_q == StIdle) & ~any_need & ~rst_i & ~abort;

endmodule
